mdu_sequencer: RTL

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It sits beside the EX-stage ALU, decodes the same 6-bit R-type `func` field the ALU control path uses, and runs 32-iteration shift-add multiplication or restoring division into the HI/LO registers. While it is busy, it stalls the pipeline for any further multiply/divide issue or HI/LO read.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mdu_iter_core.sv | 41 ++++
 rtl/mdu_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: R-type func codes for the
// multiply/divide unit and the sequencer state encoding.
package mips_pkg;

    // R-type func field values handled by the multiply/divide unit.
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    // Upper four func bits common to all four MDU instructions.
    localparam logic [3:0] FUNC_MDU_PREFIX = 4'b0110;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Operation class selected by func[1].
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mdu_op_t;

    // True when func names one of mult/multu/div/divu.
    function automatic logic is_mdu_func(input logic [5:0] f);
        return (f[5:2] == FUNC_MDU_PREFIX);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: MSB-first shift-add, acc' = 2*acc + (b[31-cnt] ? a : 0).
// Divide:   restoring step on a 33-bit partial remainder held in acc[32:0],
//           bringing in dividend bit a[31-cnt] and emitting one quotient bit.
module mdu_iter_core
    import mips_pkg::*;
(
    input  mdu_op_t     i_op,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_mag_a,
    input  logic [31:0] i_mag_b,
    input  logic [4:0]  i_cnt,
    output logic [63:0] o_acc,
    output logic        o_q_bit
);

    logic [4:0]  w_bit_idx;
    logic [32:0] w_shift;
    logic [32:0] w_divisor;
    logic [32:0] w_diff;
    logic        w_ge;

    assign w_bit_idx = 5'd31 - i_cnt;
    assign w_divisor = {1'b0, i_mag_b};
    assign w_shift   = {i_acc[31:0], i_mag_a[w_bit_idx]};
    assign w_diff    = w_shift - w_divisor;
    assign w_ge      = (w_shift >= w_divisor);

    // Select the multiply or divide step result.
    always_comb begin
        o_acc   = i_acc;
        o_q_bit = 1'b0;
        if (i_op == OP_MUL) begin
            o_acc = {i_acc[62:0], 1'b0} + (i_mag_b[w_bit_idx] ? {32'd0, i_mag_a} : 64'd0);
        end else begin
            o_acc   = {31'd0, (w_ge ? w_diff : w_shift)};
            o_q_bit = w_ge;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer beside the EX-stage ALU.
// Accepts mult/multu/div/divu, iterates 32 cycles on operand magnitudes,
// applies signs in a final FIX cycle and writes HI/LO.
// Handshake: an op is taken on a rising edge where the unit is IDLE and
// start=1 with an MDU func; while busy, start or rd_hilo raises stall and
// the pipeline holds the instruction until it can be accepted or read.
module mdu_sequencer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hilo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_t  dbg_state
);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    logic [4:0]  r_cnt;
    mdu_op_t     r_op;
    logic        r_neg_res;   // result (product / quotient) must be negated
    logic        r_a_neg;     // remainder takes sign of dividend
    logic        r_b_zero;
    logic [31:0] r_ma;
    logic [31:0] r_mb;
    logic [63:0] r_acc;
    logic [31:0] r_quo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_acc_nxt;
    logic        w_q_bit;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

    assign w_accept = (r_state == IDLE) && start && is_mdu_func(func);
    assign w_a_neg  = ~func[0] & a[31];
    assign w_b_neg  = ~func[0] & b[31];
    // Two's-complement negate; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    assign w_mag_a  = w_a_neg ? (32'd0 - a) : a;
    assign w_mag_b  = w_b_neg ? (32'd0 - b) : b;

    mdu_iter_core u_core (
        .i_op    (r_op),
        .i_acc   (r_acc),
        .i_mag_a (r_ma),
        .i_mag_b (r_mb),
        .i_cnt   (r_cnt),
        .o_acc   (w_acc_nxt),
        .o_q_bit (w_q_bit)
    );

    // Next-state logic for the IDLE -> RUN -> FIX -> IDLE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (r_cnt == 5'd31) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sign fix-up and final HI/LO values, used only in FIX.
    always_comb begin
        w_prod_fix = r_neg_res ? (64'd0 - r_acc) : r_acc;
        w_quo_fix  = r_neg_res ? (32'd0 - r_quo) : r_quo;
        w_rem_fix  = r_a_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_hi_res   = w_prod_fix[63:32];
        w_lo_res   = w_prod_fix[31:0];
        if (r_op == OP_DIV) begin
            // Divide by zero leaves R = |a|, so the remainder fix-up already
            // restores the raw dividend; only the quotient is overridden.
            w_hi_res = w_rem_fix;
            w_lo_res = r_b_zero ? 32'hFFFF_FFFF : w_quo_fix;
        end
    end

    // State register, operand latches, iteration datapath and HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_op      <= OP_MUL;
            r_neg_res <= 1'b0;
            r_a_neg   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_ma      <= 32'd0;
            r_mb      <= 32'd0;
            r_acc     <= 64'd0;
            r_quo     <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_op      <= func[1] ? OP_DIV : OP_MUL;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_a_neg   <= w_a_neg;
                r_b_zero  <= (b == 32'd0);
                r_ma      <= w_mag_a;
                r_mb      <= w_mag_b;
                r_acc     <= 64'd0;
                r_quo     <= 32'd0;
                r_cnt     <= 5'd0;
            end else if (r_state == RUN) begin
                r_acc <= w_acc_nxt;
                r_quo <= {r_quo[30:0], w_q_bit};
                r_cnt <= r_cnt + 5'd1;
            end else if (r_state == FIX) begin
                r_hi   <= w_hi_res;
                r_lo   <= w_lo_res;
                r_done <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign stall     = busy & (start | rd_hilo);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule
